dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the single-cycle RISC-V core: the memory side of the core's load/store port.
- Store path: `we`, `a`, `wd`.
- Load path: `rd`, combinational.
- Maps a word-addressed RAM into the low half of the address space.
- Maps an MMIO region into the high half: a byte-wide console transmit FIFO with valid/ready drain, plus an optional cycle counter.

## Interface
Parameters:
- `RAM_WORDS`, 64: RAM depth in 32-bit words; power of two.
- `TXQ_DEPTH`, 4: console FIFO depth in bytes; power of two, ≥2.

Ports:
- `clk`  in  1  — sole clock; all state updates on rising edge.
- `reset`  in  1  — synchronous, active-high.
- `we`  in  1  — store strobe from the core's MemWrite.
- `a`  in  32  — byte address from the core's ALUResult.
- `wd`  in  32  — store data from the core's WriteData.
- `rd`  out  32  — load data to the core's ReadData; combinational from `a` and current state.
- `tx_data`  out  8  — FIFO head byte; 0 when empty.
- `tx_valid`  out  1  — FIFO non-empty.
- `tx_ready`  in  1  — downstream consumer accepts the head byte.

## Operation
Address decode:
- `a[31]=0` selects RAM at word index `a[log2(RAM_WORDS)+1:2]`. Upper bits and `a[1:0]` are ignored, so addresses alias modulo `4*RAM_WORDS`.
- `a[31]=1` selects MMIO, decoded on `a[3:2]`. All other MMIO bits are ignored.
  - `0x8000_0000` TXDATA: a write pushes `wd[7:0]`; reads return 0.
  - `0x8000_0004` STATUS: reads return bit0 full, bit1 empty, bit2 overflow (sticky), bits[15:8] occupancy count, others 0. Any write clears overflow.
  - `0x8000_0008` CYCLE: see Configuration.
  - `0x8000_000C`: reads return 0; writes ignored.

RAM:
- Write of `wd` at the edge when `we=1`.
- Read is asynchronous.
- Contents are not reset and have no initial value.

TX FIFO:
- Push condition: `we` with TXDATA selected.
- Pop condition: `tx_valid && tx_ready`.
- Full and empty are evaluated on the pre-edge count. A push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
- Push and pop in the same cycle when neither full nor empty: count is unchanged and both take effect.
- Pop when empty: impossible, because `tx_valid=0`.
- Read and write pointers wrap modulo `TXQ_DEPTH`.
- Overflow: a clear and a new overflow in the same cycle is impossible, because the two are different addresses.

## Timing
- Reads: zero latency, valid in the same cycle as `a`.
- Stores: visible to reads from the cycle after the `we` edge.
- FIFO: a push at edge N gives `tx_valid=1` in cycle N+1. A pop at edge N advances `tx_data` in cycle N+1.
- Reset values:
  - FIFO empty, pointers 0.
  - `tx_valid=0`, `tx_data=0`.
  - overflow 0.
  - CYCLE 0.
  - `rd` reflects the reset state: STATUS reads `0x0000_0002`.
- Reset mid-operation: queued bytes are discarded. A store or pop coincident with reset is ignored. RAM is untouched.

## Configuration
`DMEM_CYCLE_COUNTER_EN`:
- Defined:
  - CYCLE is a 32-bit counter, incremented every non-reset cycle, wrapping `0xFFFF_FFFF`→0.
  - A write to CYCLE loads `wd` at that edge; the counter increments from there on the following edges.
  - Reads return the current value.
- Undefined: no counter register; CYCLE reads 0 and writes are ignored.

## Structure
- `dmem_pkg`:
  - MMIO base `32'h8000_0000`.
  - Register offsets TXDATA/STATUS/CYCLE.
  - STATUS bit positions and count field range.
  - Region-select enum {SEL_RAM, SEL_TXDATA, SEL_STATUS, SEL_CYCLE, SEL_NONE}.
- Sub-module `tx_fifo`:
  - Parameterized by depth.
  - push/pop/full/empty/count/head.
  - Drop-on-full behaviour.

## Test plan
- RAM: store `0xDEAD_BEEF` at `0x10`, then read `0x10` → `0xDEAD_BEEF`. Read `0x10+4*RAM_WORDS` → same value (alias). Read `0x13` → same word.
- FIFO basic: with `tx_ready=0`, write 0x41, 0x42 to TXDATA → `tx_valid=1`, `tx_data=0x41`, STATUS=`0x0000_0200`. Raise `tx_ready` for 2 cycles → 0x41 then 0x42 drained, STATUS=`0x0000_0002`.
- Overflow: with `tx_ready=0`, push 5 bytes at depth 4 → 5th dropped, STATUS=`0x0000_0405`. Write STATUS → `0x0000_0401`. Drain yields exactly the first 4 bytes in order.
- Simultaneous: with count=2 and head popping, push in the same cycle → count stays 2, order preserved. With count=4, push+pop in the same cycle → count 3, overflow set.
- Reset mid-stream: with 3 bytes queued, assert `reset` 1 cycle → `tx_valid=0`, STATUS=`0x0000_0002`, RAM contents retained.
- CYCLE (macro defined): after reset read 0, then N cycles later read N. Write `0xFFFF_FFFE` → reads `0xFFFF_FFFE`, `0xFFFF_FFFF`, 0 on successive cycles. Macro undefined: always 0.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_pkg : address map, STATUS layout and region decode for dmem_responder |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;

  localparam logic [3:0]  OFF_TXDATA = 4'h0;
  localparam logic [3:0]  OFF_STATUS = 4'h4;
  localparam logic [3:0]  OFF_CYCLE  = 4'h8;

  localparam int STAT_FULL   = 0;
  localparam int STAT_EMPTY  = 1;
  localparam int STAT_OVF    = 2;
  localparam int STAT_CNT_LO = 8;
  localparam int STAT_CNT_HI = 15;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TXDATA,
    SEL_STATUS,
    SEL_CYCLE,
    SEL_NONE
  } sel_e;

  // Only bit 31 and bits [3:2] take part in the decode; everything else aliases.
  function automatic sel_e decode_sel(input logic [31:0] addr);
    sel_e s;
    if (addr[31] != MMIO_BASE[31]) begin
      s = SEL_RAM;
    end else begin
      case ({addr[3:2], 2'b00})
        OFF_TXDATA: s = SEL_TXDATA;
        OFF_STATUS: s = SEL_STATUS;
        OFF_CYCLE:  s = SEL_CYCLE;
        default:    s = SEL_NONE;
      endcase
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_fifo : byte FIFO, drops pushes when full (dropped pulses for the caller)|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic                     dropped,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               head
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  logic [7:0] mem [DEPTH];
  ptr_t       wr_ptr;
  ptr_t       rd_ptr;
  cnt_t       cnt;
  logic       do_push;
  logic       do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dropped = push && full;
  assign count   = cnt;
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + cnt_t'(1);
        2'b01:   cnt <= cnt - cnt_t'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_responder : RAM + console/cycle MMIO; DMEM_CYCLE_COUNTER_EN adds CYCLE|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int RAM_WORDS = 64,
  parameter int TXQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int CW  = $clog2(TXQ_DEPTH) + 1;

  sel_e            sel;
  logic [RAW-1:0]  ram_idx;
  logic [31:0]     ram [RAM_WORDS];
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_dropped;
  logic [CW-1:0]   fifo_count;
  logic [7:0]      cnt8;
  logic            overflow;
  logic [31:0]     status_word;
  logic [31:0]     cycle_val;
  logic            unused_addr;

  assign sel         = decode_sel(a);
  assign ram_idx     = a[RAW+1:2];
  assign unused_addr = ^{a[30:4], a[1:0]};

  always_ff @(posedge clk) begin
    if (!reset && we && (sel == SEL_RAM)) begin
      ram[ram_idx] <= wd;
    end
  end

  tx_fifo #(
    .DEPTH (TXQ_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (we && (sel == SEL_TXDATA)),
    .push_data (wd[7:0]),
    .pop       (tx_valid && tx_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dropped   (fifo_dropped),
    .count     (fifo_count),
    .head      (tx_data)
  );

  assign tx_valid = !fifo_empty;

  // Writes to STATUS and a dropped push never coincide (different addresses).
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (we && (sel == SEL_STATUS)) begin
      overflow <= 1'b0;
    end else if (fifo_dropped) begin
      overflow <= 1'b1;
    end
  end

  if (CW >= 8) begin : g_cnt_trunc
    assign cnt8 = fifo_count[7:0];
  end else begin : g_cnt_ext
    assign cnt8 = {{(8-CW){1'b0}}, fifo_count};
  end

  always_comb begin
    status_word                          = '0;
    status_word[STAT_FULL]               = fifo_full;
    status_word[STAT_EMPTY]              = fifo_empty;
    status_word[STAT_OVF]                = overflow;
    status_word[STAT_CNT_HI:STAT_CNT_LO] = cnt8;
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (we && (sel == SEL_CYCLE)) begin
      cycle_cnt <= wd;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign cycle_val = cycle_cnt;
`else
  assign cycle_val = '0;
`endif

  always_comb begin
    rd = '0;
    case (sel)
      SEL_RAM:    rd = ram[ram_idx];
      SEL_STATUS: rd = status_word;
      SEL_CYCLE:  rd = cycle_val;
      default:    rd = '0;
    endcase
  end

endmodule
`default_nettype wire
